// File: rtl/and_tree_ctl_pkg.sv
// and_tree_ctl_pkg: shared state encoding and default constants for the AND-tree sequencer.
// Rev 1.0
`default_nettype none

package and_tree_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    RESULT  = 2'd2,
    NEUTRAL = 2'd3
  } state_t;

  localparam int DEF_N_IN    = 4;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_SETTLE  = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_RTZ     = 1;
  localparam int DEF_TIMER_W = $clog2(DEF_TIMEOUT + 1);

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/and_tree_seq_ctl_sync_2ff.sv
// sync_2ff: two-flop synchroniser for the asynchronous tree output, reset to 0.
// Rev 1.0
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/and_tree_seq_ctl.sv
// and_tree_seq_ctl: applies vectors to an external AND tree, waits for z to settle, reports result.
// Rev 1.0
`default_nettype none

module and_tree_seq_ctl
  import and_tree_ctl_pkg::*;
#(
  parameter int N_IN    = DEF_N_IN,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RTZ     = DEF_RTZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [N_IN-1:0]  vec_data,
  output logic [N_IN-1:0]  tree_in,
  input  logic             tree_z,
  output logic             res_valid,
  output logic             res_pass,
  output logic             res_timeout,
  output logic             neutral_err,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int TIMER_W = cnt_width(TIMEOUT);
  localparam int SET_W   = cnt_width(SETTLE);
  localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(TIMEOUT);
  localparam logic [SET_W-1:0]   SETTLE_V  = SET_W'(SETTLE);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  state_t             state, state_nxt;
  logic               z_sync;
  logic               exp_z;
  logic               expected;
  logic [TIMER_W-1:0] timer;
  logic [SET_W-1:0]   settle;
  logic [SET_W-1:0]   settle_inc;
  logic               match;
  logic               settled;
  logic               timed_out;
  logic               accept;
  logic               fail_evt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (tree_z),
    .q   (z_sync)
  );

  // NEUTRAL always waits for the tree to return to zero.
  assign expected   = (state == NEUTRAL) ? 1'b0 : exp_z;
  assign match      = (z_sync == expected);
  assign settle_inc = settle + SET_W'(1);
  assign settled    = match && (settle_inc == SETTLE_V);
  assign timed_out  = (timer == TIMEOUT_V);
  assign accept     = (state == IDLE) && vec_valid && vec_ready;
  assign fail_evt   = ((state == RESULT) && res_timeout) ||
                      ((state == NEUTRAL) && timed_out && !settled);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EVAL;
      EVAL:    if (settled || timed_out) state_nxt = RESULT;
      RESULT:  state_nxt = (RTZ != 0) ? NEUTRAL : IDLE;
      NEUTRAL: if (settled || timed_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_ready   <= 1'b1;
      busy        <= 1'b0;
      tree_in     <= '0;
      exp_z       <= 1'b0;
      timer       <= '0;
      settle      <= '0;
      res_valid   <= 1'b0;
      res_pass    <= 1'b0;
      res_timeout <= 1'b0;
      neutral_err <= 1'b0;
      err_count   <= '0;
    end else begin
      vec_ready   <= (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);
      res_valid   <= 1'b0;
      res_pass    <= 1'b0;
      res_timeout <= 1'b0;
      if (fail_evt && (err_count != CNT_MAX)) err_count <= err_count + 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            exp_z   <= &vec_data;
            tree_in <= vec_data;
            timer   <= '0;
            settle  <= '0;
          end
        end
        EVAL, NEUTRAL: begin
          timer  <= timer + 1'b1;
          settle <= match ? settle_inc : '0;
          // Settle wins over timeout when both land on the same cycle.
          if ((state == EVAL) && (settled || timed_out)) begin
            res_valid   <= 1'b1;
            res_pass    <= settled;
            res_timeout <= !settled;
          end
          if ((state == NEUTRAL) && timed_out && !settled) neutral_err <= 1'b1;
        end
        RESULT: begin
          if (RTZ != 0) begin
            tree_in <= '0;
            timer   <= '0;
            settle  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
